stage_if: RTL and testbench

//  Instruction-fetch stage, directly upstream of the decode stage. Owns the PC.

---
 rtl/stage_if.sv | 138 +++++++++++++
 tb/tb_stage_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// stage_if: instruction fetch over a shared 8-bit memory port.
// Owns the PC, assembles four LE bytes, hands {pc, inst} to decode.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  output logic        stall_if,
  input  logic        br,
  input  logic [31:0] br_addr,
  input  logic        mem_grant,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_din,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [2:0]  cnt;
  logic [2:0]  cnt_d;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] inst;
  logic [31:0] inst_d;
  logic [31:0] addr_d;
  logic [31:0] ipc_d;
  logic [31:0] iinst_d;
  logic [31:0] word;
  logic        take_br;
  logic        unused_stall;

  assign unused_stall = ^stall[5:3];
  assign take_br = br && !stall[2];
  assign word = {mem_din, inst[23:0]};

  // Handshake outputs; forced low while reset is held.
  assign mem_req = reset && (state != HOLD);
  assign stall_if = reset &&
    ((state == IDLE) ||
     ((state == FETCH) && (cnt != 3'd4)));

  // Next-state, PC, fetch address and output register.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pc_d    = pc;
    inst_d  = inst;
    addr_d  = mem_addr;
    ipc_d   = if_pc;
    iinst_d = stall[1] ? if_inst : NOP;
    if (take_br) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      pc_d    = br_addr;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_grant && !stall[0]) begin
            addr_d  = pc;
            cnt_d   = 3'd0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (!mem_grant) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            inst_d  = '0;
          end else begin
            if (cnt <= 3'd2)
              addr_d = pc + {29'd0, cnt} + 32'd1;
            case (cnt)
              3'd1: inst_d[7:0]   = mem_din;
              3'd2: inst_d[15:8]  = mem_din;
              3'd3: inst_d[23:16] = mem_din;
              default: ;
            endcase
            if (cnt == 3'd4) begin
              inst_d = word;
              cnt_d  = 3'd0;
              if (!stall[1]) begin
                ipc_d   = pc;
                iinst_d = word;
                pc_d    = pc + 32'd4;
                state_d = IDLE;
              end else begin
                state_d = HOLD;
              end
            end else begin
              cnt_d = cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (!stall[1]) begin
            ipc_d   = pc;
            iinst_d = inst;
            pc_d    = pc + 32'd4;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      pc       <= RESET_PC;
      inst     <= '0;
      mem_addr <= '0;
      if_pc    <= '0;
      if_inst  <= NOP;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pc       <= pc_d;
      inst     <= inst_d;
      mem_addr <= addr_d;
      if_pc    <= ipc_d;
      if_inst  <= iinst_d;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: directed vectors plus hand sequences
// for stall, redirect, grant loss and async reset.
module tb_stage_if;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h00A0_0513;
  localparam logic [31:0] I1  = 32'h1234_5678;
  localparam logic [31:0] I2  = 32'hDEAD_BEEF;
  localparam logic [31:0] IX  = 32'h1122_3344;
  localparam logic [31:0] I3  = 32'hCAFE_F00D;
  localparam logic [31:0] I4  = 32'h0BAD_C0DE;
  localparam logic [31:0] I5  = 32'h0102_0304;
  localparam logic [5:0]  S1  = 6'b000010;
  localparam logic [5:0]  S2  = 6'b000100;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        stall_if;
  logic        br;
  logic [31:0] br_addr;
  logic        mem_grant;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  stage_if dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .stall_if (stall_if),
    .br       (br),
    .br_addr  (br_addr),
    .mem_grant(mem_grant),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .if_pc    (if_pc),
    .if_inst  (if_inst)
  );

  logic [7:0] mem [0:1023];

  always @(posedge clk) mem_din <= mem[mem_addr[9:0]];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0]  stall;
    logic        br;
    logic [31:0] ba;
    logic        gnt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        req;
    logic        sif;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic putw(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  task automatic add(input logic [5:0] s, input logic b,
                     input logic [31:0] ba, input logic [31:0] p,
                     input logic [31:0] ins, input logic rq,
                     input logic sf);
    vec_t v;
    v.stall = s;
    v.br    = b;
    v.ba    = ba;
    v.gnt   = 1'b1;
    v.pc    = p;
    v.inst  = ins;
    v.req   = rq;
    v.sif   = sf;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    stall = '0;
    br = 1'b0;
    br_addr = '0;
    mem_grant = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    putw(0, I0);
    putw(4, I1);
    putw(8, I2);
    putw(12, IX);
    putw(256, I3);
    putw(260, I4);
    putw(264, I5);

    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, NOP, 1, 1);
    add(0, 0, 0, 0, NOP, 1, 0);
    add(0, 0, 0, 0, I0, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, NOP, 1, 1);
    add(0, 0, 0, 0, NOP, 1, 0);
    add(0, 0, 0, 4, I1, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 4, NOP, 1, 1);
    add(S1, 0, 0, 4, NOP, 1, 0);
    add(S1, 0, 0, 4, NOP, 0, 0);
    add(S1, 0, 0, 4, NOP, 0, 0);
    add(0, 0, 0, 8, I2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 8, NOP, 1, 1);
    add(0, 1, 32'h100, 8, NOP, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 8, NOP, 1, 1);
    add(0, 0, 0, 8, NOP, 1, 0);
    add(0, 0, 0, 32'h100, I3, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_inst", 64'(if_inst), 64'(NOP));
    chk("rst_req_sif", 64'({mem_req, stall_if}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    reset = 1'b1;

    foreach (vq[i]) begin
      stall = vq[i].stall;
      br = vq[i].br;
      br_addr = vq[i].ba;
      mem_grant = vq[i].gnt;
      step;
      chk($sformatf("v%0d_out", i), {if_pc, if_inst},
          {vq[i].pc, vq[i].inst});
      chk($sformatf("v%0d_hs", i), 64'({mem_req, stall_if}),
          64'({vq[i].req, vq[i].sif}));
    end
    stall = '0;
    br = 1'b0;

    repeat (4) step;
    mem_grant = 1'b0;
    step;
    chk("gdrop_sif", 64'(stall_if), 64'd1);
    chk("gdrop_addr", 64'(mem_addr), 64'h107);
    step;
    chk("gdrop2_addr", 64'(mem_addr), 64'h107);
    mem_grant = 1'b1;
    step;
    chk("refetch_addr", 64'(mem_addr), 64'h104);
    repeat (5) step;
    chk("refetch_out", {if_pc, if_inst}, {32'h104, I4});

    step;
    br = 1'b1;
    br_addr = 32'h8;
    stall = S2;
    step;
    chk("br_held_addr", 64'(mem_addr), 64'h109);
    stall = '0;
    step;
    chk("br_take_addr", 64'(mem_addr), 64'h109);
    chk("br_take_sif", 64'(stall_if), 64'd1);
    br = 1'b0;
    step;
    chk("br_fetch_addr", 64'(mem_addr), 64'h8);
    repeat (5) step;
    chk("br_out", {if_pc, if_inst}, {32'h8, I2});

    repeat (5) step;
    chk("cmp_sif", 64'(stall_if), 64'd0);
    br = 1'b1;
    br_addr = 32'h100;
    step;
    chk("cmp_drop", {if_pc, if_inst}, {32'h8, NOP});
    br = 1'b0;
    repeat (6) step;
    chk("cmp_next", {if_pc, if_inst}, {32'h100, I3});

    repeat (3) step;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out", {if_pc, if_inst}, {32'h0, NOP});
    chk("arst_hs", 64'({mem_req, stall_if}), 64'd0);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    #2;
    reset = 1'b1;
    repeat (6) step;
    chk("arst_refetch", {if_pc, if_inst}, {32'h0, I0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
